// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO bring-up blocks: default sizes, the test
// pattern offset and the read-checker state encoding.
package fifo_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 8;
    localparam int unsigned DEFAULT_CNT_W     = 8;
    localparam int unsigned DEFAULT_NUM_WORDS = 128;
    localparam int unsigned PATTERN_OFFSET    = 23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_read_checker_if.sv
// Read port of a first-word-fall-through FIFO: head word, empty flag, pop request.
interface fifo_read_checker_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             read_en;
    logic             read_empty;
    logic [WIDTH-1:0] data_in;

    // master: the consumer issuing pops; slave: the FIFO presenting data
    modport master (output read_en, input read_empty, input data_in);
    modport slave  (input read_en, output read_empty, output data_in);
endinterface

// File: rtl/fifo_pattern_gen.sv
// Deterministic word generator: emits (k + OFFSET) mod 2^WIDTH, loads OFFSET
// on clear and advances on step. Shared by the write and read sides.
module fifo_pattern_gen
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned OFFSET = PATTERN_OFFSET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = WIDTH'(OFFSET);
        end else if (step) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fifo_read_checker.sv
// Read-domain consumer for FIFO bring-up: pops NUM_WORDS words, checks each
// against the write-side pattern and reports counts, first mismatch and pass.
module fifo_read_checker
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int unsigned OFFSET    = PATTERN_OFFSET,
    parameter int unsigned CNT_W     = DEFAULT_CNT_W
) (
    input  logic                 read_clk,
    input  logic                 reset,
    input  logic                 start,
    fifo_read_checker_if.master  rd,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     word_count,
    output logic [CNT_W-1:0]     error_count,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [WIDTH-1:0]     first_err_data,
    output logic [WIDTH-1:0]     first_err_exp
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e state_q, state_d;

    logic             read_en_q, read_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [CNT_W-1:0] error_count_q, error_count_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [WIDTH-1:0] first_err_data_q, first_err_data_d;
    logic [WIDTH-1:0] first_err_exp_q, first_err_exp_d;
    logic             err_seen_q, err_seen_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic [CNT_W-1:0] cmp_idx_q, cmp_idx_d;
    logic [WIDTH-1:0] cmp_data_q, cmp_data_d;
    logic [WIDTH-1:0] cmp_exp_q, cmp_exp_d;

    logic             start_c;
    logic             pop_c;
    logic             last_pop_c;
    logic             mismatch_c;
    logic [WIDTH-1:0] exp_value;

    assign start_c    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign pop_c      = read_en_q && !rd.read_empty;
    assign last_pop_c = pop_c && (word_count_q == LAST_CNT);
    assign mismatch_c = cmp_valid_q && (cmp_data_q != cmp_exp_q);

    fifo_pattern_gen #(
        .WIDTH  (WIDTH),
        .OFFSET (OFFSET)
    ) u_pattern_gen (
        .clk   (read_clk),
        .reset (reset),
        .clear (start_c),
        .step  (pop_c),
        .value (exp_value)
    );

    always_ff @(posedge read_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (last_pop_c) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        read_en_d        = (state_d == ST_RUN);
        busy_d           = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d           = (state_d == ST_DONE);
        word_count_d     = word_count_q;
        error_count_d    = error_count_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;
        first_err_exp_d  = first_err_exp_q;
        err_seen_d       = err_seen_q;
        cmp_valid_d      = 1'b0;
        cmp_idx_d        = cmp_idx_q;
        cmp_data_d       = cmp_data_q;
        cmp_exp_d        = cmp_exp_q;

        if (pop_c) begin
            cmp_valid_d  = 1'b1;
            cmp_idx_d    = word_count_q;
            cmp_data_d   = rd.data_in;
            cmp_exp_d    = exp_value;
            word_count_d = word_count_q + CNT_W'(1);
        end

        if (mismatch_c) begin
            if (error_count_q != CNT_MAX) begin
                error_count_d = error_count_q + CNT_W'(1);
            end
            if (!err_seen_q) begin
                err_seen_d       = 1'b1;
                first_err_idx_d  = cmp_idx_q;
                first_err_data_d = cmp_data_q;
                first_err_exp_d  = cmp_exp_q;
            end
        end

        if (start_c) begin
            word_count_d     = '0;
            error_count_d    = '0;
            first_err_idx_d  = '0;
            first_err_data_d = '0;
            first_err_exp_d  = '0;
            err_seen_d       = 1'b0;
        end

        pass_d = done_d && (error_count_d == '0);
    end

    always_ff @(posedge read_clk) begin
        if (reset) begin
            read_en_q        <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            word_count_q     <= '0;
            error_count_q    <= '0;
            first_err_idx_q  <= '0;
            first_err_data_q <= '0;
            first_err_exp_q  <= '0;
            err_seen_q       <= 1'b0;
            cmp_valid_q      <= 1'b0;
            cmp_idx_q        <= '0;
            cmp_data_q       <= '0;
            cmp_exp_q        <= '0;
        end else begin
            read_en_q        <= read_en_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            word_count_q     <= word_count_d;
            error_count_q    <= error_count_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
            first_err_exp_q  <= first_err_exp_d;
            err_seen_q       <= err_seen_d;
            cmp_valid_q      <= cmp_valid_d;
            cmp_idx_q        <= cmp_idx_d;
            cmp_data_q       <= cmp_data_d;
            cmp_exp_q        <= cmp_exp_d;
        end
    end

    assign rd.read_en     = read_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign word_count     = word_count_q;
    assign error_count    = error_count_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;
    assign first_err_exp  = first_err_exp_q;

endmodule
